wave_oscillator: RTL and testbench

//  Numerically-controlled oscillator: the sample source upstream of waveform_comb.

---
 rtl/osc_pkg.sv | 14 +
 rtl/wave_oscillator_strobe.sv | 32 +++
 rtl/wave_oscillator.sv | 77 +++++++
 tb/tb_wave_oscillator.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared types and constants for the wave oscillator voice.
package osc_pkg;

  typedef enum logic [1:0] {
    SQUARE   = 2'd0,
    SAW      = 2'd1,
    TRIANGLE = 2'd2,
    MUTE     = 2'd3
  } wave_t;

  localparam int         SAMPLE_W = 8;
  localparam logic [7:0] MIDSCALE = 8'h80;

endpackage

// File: rtl/wave_oscillator_strobe.sv
// Clock divider producing a one-cycle sample-rate strobe every CLK_DIV enabled cycles.
module sample_strobe #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int               CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign strobe = (div_cnt == LAST) && en;

  // Divider count: held at zero while disabled or restarted, wraps after LAST.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
    end else if (clr || !en) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wave_oscillator.sv
// Numerically-controlled oscillator: divided strobe advances a phase accumulator,
// the phase is shaped into an 8-bit unsigned sample and announced with a done pulse.
module wave_oscillator
  import osc_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int ACC_W   = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic                phase_rst,
  input  logic [ACC_W-1:0]    freq_word,
  input  logic [1:0]          wave_sel,
  output logic [SAMPLE_W-1:0] sample,
  output logic                done
);

  logic             strobe_p0;
  logic             vld_p1;
  logic [ACC_W-1:0] phase_p1;

  // Map the top byte of the phase onto the selected waveform.
  function automatic logic [SAMPLE_W-1:0] shape(input logic [7:0] p, input wave_t ws);
    logic [SAMPLE_W-1:0] s;
    s = MIDSCALE;
    case (ws)
      SQUARE:   s = p[7] ? 8'h00 : 8'hFF;
      SAW:      s = p;
      TRIANGLE: s = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      MUTE:     s = MIDSCALE;
      default:  s = MIDSCALE;
    endcase
    return s;
  endfunction

  sample_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .clk    (clk),
    .n_rst  (n_rst),
    .en     (en),
    .clr    (phase_rst),
    .strobe (strobe_p0)
  );

  // ---- stage p0 -> p1: phase accumulate on strobe ----
  // Phase wraps modulo 2^ACC_W; a restart wins over a coincident strobe and drops its pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= strobe_p0 && !phase_rst;
      if (phase_rst) begin
        phase_p1 <= '0;
      end else if (strobe_p0) begin
        phase_p1 <= phase_p1 + freq_word;
      end
    end
  end

  // ---- stage p1 -> output: shape and announce ----
  // Sample updates only one cycle after a strobe; done mirrors that update for one cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample <= '0;
      done   <= 1'b0;
    end else begin
      done <= vld_p1;
      if (vld_p1) begin
        sample <= shape(phase_p1[ACC_W-1 -: 8], wave_t'(wave_sel));
      end
    end
  end

endmodule

// File: tb/tb_wave_oscillator.sv
// Scoreboard bench for wave_oscillator: randomized and directed stimulus, reference model
// predicts each done pulse (edge index and sample); a monitor checks every cycle.
module tb_wave_oscillator;

  localparam int CLK_DIV = 4;
  localparam int ACC_W   = 16;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             en = 1'b0;
  logic             phase_rst = 1'b0;
  logic [ACC_W-1:0] freq_word = '0;
  logic [1:0]       wave_sel = 2'd1;
  logic [7:0]       sample;
  logic             done;

  always #5 clk = ~clk;

  wave_oscillator #(
    .CLK_DIV (CLK_DIV),
    .ACC_W   (ACC_W)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .en        (en),
    .phase_rst (phase_rst),
    .freq_word (freq_word),
    .wave_sel  (wave_sel),
    .sample    (sample),
    .done      (done)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  smp;
  } exp_t;

  exp_t q[$];

  int unsigned edge_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 32'd1;

  // Reference model state: phase as plain integer, count of consecutive enabled edges
  // since the last restart, and whether a sample is owed at the next edge.
  int unsigned m_phase = 0;
  int unsigned m_ticks = 0;
  bit          m_pend = 0;

  function automatic logic [7:0] ref_shape(input int unsigned ph, input logic [1:0] ws);
    int unsigned p;
    p = (ph >> (ACC_W - 8)) & 32'd255;
    case (ws)
      2'd0:    return (p >= 128) ? 8'h00 : 8'hFF;
      2'd1:    return 8'(p);
      2'd2:    return (p < 128) ? 8'(2 * p) : 8'(255 - 2 * (p - 128));
      default: return 8'h80;
    endcase
  endfunction

  // Drive one clock's worth of inputs and predict the effect of the coming edge.
  task automatic cyc_step(input bit rn, input bit e, input bit pr,
                          input logic [ACC_W-1:0] fw, input logic [1:0] ws);
    @(negedge clk);
    n_rst = rn; en = e; phase_rst = pr; freq_word = fw; wave_sel = ws;
    if (!rn) begin
      m_phase = 0; m_ticks = 0; m_pend = 0;
    end else begin
      if (m_pend) begin
        q.push_back('{cyc: edge_cnt + 32'd1, smp: ref_shape(m_phase, ws)});
        m_pend = 0;
      end
      if (pr) begin
        m_phase = 0; m_ticks = 0;
      end else if (e) begin
        m_ticks++;
        if (m_ticks == CLK_DIV) begin
          m_ticks = 0;
          m_phase = (m_phase + fw) % (32'd1 << ACC_W);
          m_pend  = 1;
        end
      end else begin
        m_ticks = 0;
      end
    end
  endtask

  task automatic run(input int n, input logic [ACC_W-1:0] fw, input logic [1:0] ws);
    for (int i = 0; i < n; i++) cyc_step(1'b1, 1'b1, 1'b0, fw, ws);
  endtask

  // Monitor: one check per cycle, just after each rising edge.
  logic [7:0] exp_last = 8'h00;
  bit         prev_done = 0;
  bit         exp_done;
  exp_t       ent;

  always @(posedge clk) begin
    #1;
    if (!n_rst) begin
      n_cmp++;
      if (done !== 1'b0 || sample !== 8'h00) begin
        n_err++;
        $display("FAIL reset_state cyc=%0d done=%b sample=%h expected done=0 sample=00", edge_cnt, done, sample);
      end
      exp_last  = 8'h00;
      prev_done = 0;
    end else begin
      exp_done = (q.size() > 0) && (q[0].cyc == edge_cnt);
      n_cmp++;
      if (done !== exp_done) begin
        n_err++;
        $display("FAIL done_timing cyc=%0d done=%b expected %b", edge_cnt, done, exp_done);
      end
      if (exp_done) begin
        ent = q.pop_front();
        n_cmp++;
        if (sample !== ent.smp) begin
          n_err++;
          $display("FAIL sample cyc=%0d got %h expected %h", edge_cnt, sample, ent.smp);
        end
        exp_last = ent.smp;
      end else begin
        n_cmp++;
        if (sample !== exp_last) begin
          n_err++;
          $display("FAIL sample_hold cyc=%0d got %h expected %h", edge_cnt, sample, exp_last);
        end
      end
      if (done === 1'b1 && prev_done) begin
        n_err++;
        $display("FAIL double_done cyc=%0d done high two cycles, expected single pulse", edge_cnt);
      end
      prev_done = (done === 1'b1);
    end
  end

  initial begin
    // Reset held for a few cycles
    for (int i = 0; i < 3; i++) cyc_step(1'b0, 1'b0, 1'b0, '0, 2'd1);
    // SAW sweep with wrap through 0xF0 -> 0x00
    run(4 * 20, 16'h1000, 2'd1);
    // SAW with large word (downward modular steps)
    run(4 * 12, 16'hF000, 2'd1);
    // TRIANGLE then SQUARE
    run(4 * 10, 16'h2000, 2'd2);
    run(4 * 10, 16'h2000, 2'd0);
    // MUTE and frozen phase
    run(4 * 4, 16'h1234, 2'd3);
    run(4 * 4, 16'h0000, 2'd1);
    // phase_rst coinciding with a strobe
    for (int i = 0; i < 8 && m_ticks != CLK_DIV - 1; i++) run(1, 16'h1000, 2'd1);
    cyc_step(1'b1, 1'b1, 1'b1, 16'h1000, 2'd1);
    run(12, 16'h1000, 2'd1);
    // phase_rst while disabled
    cyc_step(1'b1, 1'b0, 1'b1, 16'h1000, 2'd1);
    run(12, 16'h1000, 2'd1);
    // en low for 10 cycles mid-run
    for (int i = 0; i < 10; i++) cyc_step(1'b1, 1'b0, 1'b0, 16'h1000, 2'd1);
    run(14, 16'h1000, 2'd1);
    // reset between strobe and done
    for (int i = 0; i < 8 && !m_pend; i++) run(1, 16'h1000, 2'd1);
    for (int i = 0; i < 3; i++) cyc_step(1'b0, 1'b1, 1'b0, 16'h1000, 2'd1);
    run(20, 16'h1000, 2'd1);
    // Randomized operation
    for (int i = 0; i < 3000; i++) begin
      cyc_step(($urandom % 200) != 0, ($urandom % 8) != 0, ($urandom % 40) == 0,
               (($urandom % 6) == 0) ? 16'h0000 : 16'($urandom),
               2'($urandom_range(0, 3)));
    end
    // Drain
    for (int i = 0; i < 8; i++) cyc_step(1'b1, 1'b0, 1'b0, '0, 2'd1);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected got %0d outstanding expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
